// File: rtl/crono_pkg.sv
// crono_pkg: shared types, digit limits and preset-saturation helpers for the
// crono_countdown timer.
//   crono_state_e  - controller states (idle, paused, counting, alarm)
//   *Max constants - largest legal BCD value of each digit position
//   sat_time()     - clamps a raw HH:MM:SS preset to a legal 24-hour time
package crono_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPause,
        StRun,
        StAlarm
    } crono_state_e;

    localparam logic [3:0] MinSecTensMax   = 4'd5;
    localparam logic [3:0] UnitsMax        = 4'd9;
    localparam logic [3:0] HourTensMax     = 4'd2;
    localparam logic [3:0] HourUnitsMaxTop = 4'd3;  // hour units limit when tens is 2

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    // Returns {HH, MM, SS}, each digit clamped; hour units depend on the clamped tens.
    function automatic logic [23:0] sat_time(input logic [7:0] hh, input logic [7:0] mm,
                                             input logic [7:0] ss);
        logic [3:0] ht;
        logic [3:0] hu;
        ht = sat_digit(hh[7:4], HourTensMax);
        hu = sat_digit(hh[3:0], (ht == HourTensMax) ? HourUnitsMaxTop : UnitsMax);
        return {ht, hu,
                sat_digit(mm[7:4], MinSecTensMax), sat_digit(mm[3:0], UnitsMax),
                sat_digit(ss[7:4], MinSecTensMax), sat_digit(ss[3:0], UnitsMax)};
    endfunction

endpackage

// File: rtl/crono_countdown_if.sv
// crono_countdown_if: control and time bundle between the controlling logic
// (master) and the countdown timer (slave).
//   tick                   - 1 Hz one-clock strobe
//   load, start, stop, ack - control levels / raw buttons
//   hcr_in, mcr_in, scr_in - BCD preset HH, MM, SS
//   hcr, mcr, scr          - BCD remaining time
//   running, alarm         - status
interface crono_countdown_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       stop;
    logic       ack;
    logic [7:0] hcr_in;
    logic [7:0] mcr_in;
    logic [7:0] scr_in;
    logic [7:0] hcr;
    logic [7:0] mcr;
    logic [7:0] scr;
    logic       running;
    logic       alarm;

    modport master (
        output tick, load, start, stop, ack, hcr_in, mcr_in, scr_in,
        input  hcr, mcr, scr, running, alarm
    );

    modport slave (
        input  tick, load, start, stop, ack, hcr_in, mcr_in, scr_in,
        output hcr, mcr, scr, running, alarm
    );
endinterface

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one stage of a BCD borrow chain.
//   digit, max, borrow_in -> digit_out, borrow_out
// With borrow_in high the digit decrements, wrapping 0 to max and raising
// borrow_out; otherwise the digit passes through unchanged.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);
    always_comb begin
        digit_out  = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_out  = max;
                borrow_out = 1'b1;
            end else begin
                digit_out = digit - 4'd1;
            end
        end
    end
endmodule

// File: rtl/crono_countdown.sv
// crono_countdown: HH:MM:SS BCD countdown timer with alarm.
//   clk    - clock, all state on rising edge
//   reset  - synchronous active-low reset
//   bus    - crono_countdown_if.slave (tick/load/start/stop/ack, presets,
//            remaining time, running, alarm)
// Parameter ALARM_TICKS: tick pulses the alarm stays up before auto-clear.
// Macro CRONO_AUTORELOAD_EN: on reaching zero, reload the preset, keep
// running and pulse alarm for one clock instead of entering the alarm state.
module crono_countdown
    import crono_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 10
) (
    input logic               clk,
    input logic               reset,
    crono_countdown_if.slave  bus
);
    localparam int unsigned AlarmCntW = $clog2(ALARM_TICKS + 1);

    crono_state_e         state_q, state_d;
    logic [23:0]          count_q, count_d;
    logic [AlarmCntW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic                 start_q, stop_q;
`ifdef CRONO_AUTORELOAD_EN
    logic [23:0]          preset_q, preset_d;
    logic                 pulse_q, pulse_d;
`endif

    logic        start_edge;
    logic        stop_edge;
    logic [23:0] load_val;
    logic [23:0] dec_val;
    logic [5:0]  borrow;

    assign start_edge = bus.start & ~start_q;
    assign stop_edge  = bus.stop & ~stop_q;
    assign load_val   = sat_time(bus.hcr_in, bus.mcr_in, bus.scr_in);

    // Decrement chain, seconds units first. A borrow out of the hour tens
    // only happens when the count is already 00:00:00.
    bcd_digit_dec u_s_units (
        .digit(count_q[3:0]), .max(UnitsMax), .borrow_in(1'b1),
        .digit_out(dec_val[3:0]), .borrow_out(borrow[0])
    );
    bcd_digit_dec u_s_tens (
        .digit(count_q[7:4]), .max(MinSecTensMax), .borrow_in(borrow[0]),
        .digit_out(dec_val[7:4]), .borrow_out(borrow[1])
    );
    bcd_digit_dec u_m_units (
        .digit(count_q[11:8]), .max(UnitsMax), .borrow_in(borrow[1]),
        .digit_out(dec_val[11:8]), .borrow_out(borrow[2])
    );
    bcd_digit_dec u_m_tens (
        .digit(count_q[15:12]), .max(MinSecTensMax), .borrow_in(borrow[2]),
        .digit_out(dec_val[15:12]), .borrow_out(borrow[3])
    );
    bcd_digit_dec u_h_units (
        .digit(count_q[19:16]), .max(UnitsMax), .borrow_in(borrow[3]),
        .digit_out(dec_val[19:16]), .borrow_out(borrow[4])
    );
    bcd_digit_dec u_h_tens (
        .digit(count_q[23:20]), .max(HourTensMax), .borrow_in(borrow[4]),
        .digit_out(dec_val[23:20]), .borrow_out(borrow[5])
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        alarm_cnt_d = alarm_cnt_q;
`ifdef CRONO_AUTORELOAD_EN
        preset_d    = preset_q;
        pulse_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle, StPause: begin
                if (bus.load) begin
                    count_d = load_val;
`ifdef CRONO_AUTORELOAD_EN
                    preset_d = load_val;
`endif
                    state_d = StPause;
                end else if (state_q == StPause && start_edge && count_q != 24'h0) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Stop is applied first so that reaching zero on the same tick
                // still ends in the alarm state.
                if (stop_edge) begin
                    state_d = StPause;
                end
                if (bus.tick && !borrow[5]) begin
                    count_d = dec_val;
                    if (dec_val == 24'h0) begin
`ifdef CRONO_AUTORELOAD_EN
                        count_d = preset_q;
                        pulse_d = 1'b1;
`else
                        state_d     = StAlarm;
                        alarm_cnt_d = '0;
`endif
                    end
                end
            end
            StAlarm: begin
                if (bus.ack) begin
                    state_d     = StIdle;
                    count_d     = 24'h0;
                    alarm_cnt_d = '0;
                end else if (bus.tick) begin
                    if (alarm_cnt_q == AlarmCntW'(ALARM_TICKS - 1)) begin
                        state_d     = StIdle;
                        count_d     = 24'h0;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + AlarmCntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= 24'h0;
            alarm_cnt_q <= '0;
            // Held-high buttons must not register as edges after reset.
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            alarm_cnt_q <= alarm_cnt_d;
            start_q     <= bus.start;
            stop_q      <= bus.stop;
        end
    end

`ifdef CRONO_AUTORELOAD_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            preset_q <= 24'h0;
            pulse_q  <= 1'b0;
        end else begin
            preset_q <= preset_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.alarm = (state_q == StAlarm) | pulse_q;
`else
    assign bus.alarm = (state_q == StAlarm);
`endif

    assign bus.hcr     = count_q[23:16];
    assign bus.mcr     = count_q[15:8];
    assign bus.scr     = count_q[7:0];
    assign bus.running = (state_q == StRun);

endmodule

// File: tb/tb_crono_countdown.sv
// tb_crono_countdown: scoreboard bench for crono_countdown. Expected
// {running, alarm, HH, MM, SS} entries are queued as stimulus is applied and
// compared one clock later. Build with CRONO_AUTORELOAD_EN to check reload.
module tb_crono_countdown;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crono_countdown_if bus ();

    crono_countdown #(
        .ALARM_TICKS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge and drain the scoreboard.
    task automatic cycle();
        sb_item_t it;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check_eq(it.tag, {6'b0, bus.running, bus.alarm, bus.hcr, bus.mcr, bus.scr},
                     it.val);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic run, input logic alm);
        sb_item_t it;
        it.tag = tag;
        it.val = {6'b0, run, alm, h, m, s};
        sb.push_back(it);
        cycle();
    endtask

    task automatic set_in(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.hcr_in = h;
        bus.mcr_in = m;
        bus.scr_in = s;
    endtask

    task automatic do_load(input string tag, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
        set_in(h, m, s);
        bus.load = 1'b1;
        step(tag, h, m, s, 1'b0, 1'b0);
        bus.load = 1'b0;
    endtask

    task automatic do_start(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
        bus.start = 1'b1;
        step(tag, h, m, s, 1'b1, 1'b0);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.ack   = 1'b0;
        set_in(8'h00, 8'h00, 8'h00);
        // Buttons held through reset.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        reset     = 1'b0;
        cycle();
        step("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        do_load("load_held", 8'h00, 8'h00, 8'h05);
        step("start_held", 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cycle();

        // Saturation of an out-of-range preset.
        set_in(8'h97, 8'h97, 8'h97);
        bus.load = 1'b1;
        step("sat", 8'h23, 8'h57, 8'h57, 1'b0, 1'b0);
        bus.load = 1'b0;

        // 00:01:05 through six ticks.
        do_load("ld_0105", 8'h00, 8'h01, 8'h05);
        do_start("run_0105", 8'h00, 8'h01, 8'h05);
        for (int i = 1; i <= 6; i++) begin
            bus.tick = 1'b1;
            if (i == 5)      step("tick5", 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
            else if (i == 6) step("tick6", 8'h00, 8'h00, 8'h59, 1'b1, 1'b0);
            else             cycle();
            bus.tick = 1'b0;
            cycle();
        end

        // Simultaneous start and stop edges: stop wins.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step("start_stop", 8'h00, 8'h00, 8'h59, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cycle();

        // Tick and stop in the same cycle, then ticks while paused.
        do_load("ld_30", 8'h00, 8'h00, 8'h30);
        do_start("run_30", 8'h00, 8'h00, 8'h30);
        bus.tick = 1'b1;
        bus.stop = 1'b1;
        step("tick_stop", 8'h00, 8'h00, 8'h29, 1'b0, 1'b0);
        bus.stop = 1'b0;
        step("pause_tick", 8'h00, 8'h00, 8'h29, 1'b0, 1'b0);
        bus.tick = 1'b0;
        cycle();

        // Hour borrows.
        do_load("ld_10h", 8'h10, 8'h00, 8'h00);
        do_start("run_10h", 8'h10, 8'h00, 8'h00);
        bus.tick = 1'b1;
        step("dec_10h", 8'h09, 8'h59, 8'h59, 1'b1, 1'b0);
        bus.tick = 1'b0;
        bus.stop = 1'b1;
        step("stop_10h", 8'h09, 8'h59, 8'h59, 1'b0, 1'b0);
        bus.stop = 1'b0;
        do_load("ld_20h", 8'h20, 8'h00, 8'h00);
        do_start("run_20h", 8'h20, 8'h00, 8'h00);
        bus.tick = 1'b1;
        step("dec_20h", 8'h19, 8'h59, 8'h59, 1'b1, 1'b0);
        bus.tick = 1'b0;

        // Load while running is ignored.
        set_in(8'h01, 8'h02, 8'h03);
        bus.load = 1'b1;
        step("ld_in_run", 8'h19, 8'h59, 8'h59, 1'b1, 1'b0);
        bus.load = 1'b0;
        bus.stop = 1'b1;
        step("stop_20h", 8'h19, 8'h59, 8'h59, 1'b0, 1'b0);
        bus.stop = 1'b0;

        // Start at 00:00:00 is ignored.
        do_load("ld_zero", 8'h00, 8'h00, 8'h00);
        bus.start = 1'b1;
        step("start_zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.start = 1'b0;

`ifdef CRONO_AUTORELOAD_EN
        do_load("ld_3", 8'h00, 8'h00, 8'h03);
        do_start("run_3", 8'h00, 8'h00, 8'h03);
        for (int i = 1; i <= 3; i++) begin
            bus.tick = 1'b1;
            if (i == 2)      step("ar_tick2", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
            else if (i == 3) step("ar_reload", 8'h00, 8'h00, 8'h03, 1'b1, 1'b1);
            else             cycle();
            bus.tick = 1'b0;
            if (i == 3) step("ar_pulse_end", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
            else        cycle();
        end
`else
        // Reach zero, then auto-clear after ten alarm ticks.
        do_load("ld_2", 8'h00, 8'h00, 8'h02);
        do_start("run_2", 8'h00, 8'h00, 8'h02);
        bus.tick = 1'b1;
        step("dec_2", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        bus.tick = 1'b0;
        cycle();
        bus.tick = 1'b1;
        step("alarm_on", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        bus.tick = 1'b0;
        cycle();
        for (int i = 1; i <= 10; i++) begin
            bus.tick = 1'b1;
            if (i == 9)       step("alarm_t9", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
            else if (i == 10) step("alarm_t10", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            else              cycle();
            bus.tick = 1'b0;
            cycle();
        end

        // Ack clears the alarm, with priority over a coincident tick.
        do_load("ld_1", 8'h00, 8'h00, 8'h01);
        do_start("run_1", 8'h00, 8'h00, 8'h01);
        bus.tick = 1'b1;
        step("alarm_on2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        bus.tick = 1'b0;
        cycle();
        bus.ack  = 1'b1;
        bus.tick = 1'b1;
        step("ack", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.ack  = 1'b0;
        bus.tick = 1'b0;
        cycle();
`endif

        // Reset in the middle of a run.
        do_load("ld_5", 8'h00, 8'h00, 8'h05);
        do_start("run_5", 8'h00, 8'h00, 8'h05);
        reset = 1'b0;
        step("rst_run", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/crono_countdown.md
CRONO_COUNTDOWN -- requirements
Module: crono_countdown

Interface
REQ-001 Parameter ALARM_TICKS, default 10, number of tick pulses the alarm stays asserted before auto-clear.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 tick  input  1  one-clk-wide 1 Hz strobe.
REQ-005 load  input  1  level; sample preset while high in IDLE/PAUSE.
REQ-006 start  input  1  raw button level; rising edge starts/resumes.
REQ-007 stop  input  1  raw button level; rising edge pauses.
REQ-008 ack  input  1  level; clears alarm.
REQ-009 hcr_in/mcr_in/scr_in  input  8 each  BCD preset HH, MM, SS from the time-setting editor.
REQ-010 hcr/mcr/scr  output  8 each  BCD remaining time, registered.
REQ-011 running  output  1  high in RUN.
REQ-012 alarm  output  1  high in ALARM.

Function
REQ-013 FSM states SHALL be IDLE, PAUSE, RUN, ALARM.
REQ-014 Start/stop SHALL be rising-edge detected internally; the previous-value registers reset to 1, so a button held through reset SHALL NOT fire.
REQ-015 IDLE/PAUSE + load=1: preset register and hcr/mcr/scr SHALL take the inputs next cycle; state SHALL become PAUSE.
REQ-016 On load, each digit SHALL saturate to its legal maximum: S/M tens 5, S/M units 9, H tens 2, H units 9, or 3 when H tens=2.
REQ-017 load in RUN or ALARM SHALL be ignored.
REQ-018 PAUSE + start edge with count nonzero -> RUN; with count 00:00:00 start SHALL be ignored.
REQ-019 RUN + stop edge -> PAUSE; simultaneous start and stop edges: stop wins.
REQ-020 RUN + tick: count SHALL decrement by one second, outputs valid the following cycle (latency 1).
REQ-021 BCD borrow chain: S units 0->9 borrows S tens; S tens 0->5 borrows M units; M units 0->9; M tens 0->5 borrows H units; H units 0->9 borrows H tens; e.g. 10:00:00 -> 09:59:59.
REQ-022 tick and stop edge in the same cycle: decrement applied AND state -> PAUSE.
REQ-023 Decrement reaching 00:00:00 SHALL enter ALARM in the same update; running=0, alarm=1.
REQ-024 ALARM: ack=1 or ALARM_TICKS ticks counted SHALL return to IDLE with count 00:00:00; ack has priority over tick.
REQ-025 tick in IDLE/PAUSE SHALL not change the count.

Reset
REQ-026 reset=0 at a clock edge: state IDLE, hcr=mcr=scr=8'h00, preset 0, running=0, alarm=0, alarm tick counter 0, edge registers 1.
REQ-027 Reset mid-RUN or mid-ALARM SHALL abort immediately without alarm.

Configuration
REQ-028 Macro CRONO_AUTORELOAD_EN defined: on reaching 00:00:00 in RUN, the count SHALL reload the stored preset in the same update, state stays RUN, and alarm SHALL pulse high for exactly one clk.
REQ-029 Macro undefined: REQ-023/REQ-024 behaviour; no reload logic present.

Structure
REQ-030 Shared package crono_pkg SHALL hold the state enum and digit-limit constants (5, 9, 2, 3).
REQ-031 One sub-module bcd_digit_dec (digit, max, borrow_in -> digit_out, borrow_out) SHALL be instantiated per digit.

Verification
REQ-032 Load 00:01:05, start edge, 6 ticks -> 00:00:59 after the 6th tick, running=1.
REQ-033 Load 10:00:00, start, 1 tick -> 09:59:59; load 20:00:00, 1 tick -> 19:59:59.
REQ-034 Load 00:00:02, start, 2 ticks -> 00:00:00, alarm=1, running=0; 10 more ticks -> IDLE, alarm=0.
REQ-035 Load preset 8'h97 in all three fields -> hcr=8'h23, mcr=8'h57, scr=8'h57.
REQ-036 RUN at 00:00:30, tick and stop edge in the same cycle -> 00:00:29, PAUSE; further ticks leave 00:00:29.
REQ-037 CRONO_AUTORELOAD_EN: preset 00:00:03, 3 ticks -> one-cycle alarm pulse, count 00:00:03, running=1.
